// File: rtl/pipeline_decode.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with write-through,
// hazard detection, branch/jump resolution and the ID/EX register.
// Optional build macro: DECODE_DELAY_SLOT_EN (one architectural delay slot, no flush).
module pipeline_decode #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [5:0]  JR_OP     = 6'h12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] pcPlus4Out,
  input  logic        wbRegWrite,
  input  logic [4:0]  wbRd,
  input  logic [31:0] wbData,
  input  logic        memRegWrite,
  input  logic        memMemRead,
  input  logic [4:0]  memRd,
  output logic        stall,
  output logic        zFlag,
  output logic        nzFlag,
  output logic        BEQZ,
  output logic        BNEZ,
  output logic        jump,
  output logic        jumpReg,
  output logic [25:0] value,
  output logic [31:0] extendedImm,
  output logic [31:0] registerS1,
  output logic [31:0] pcPlus4Id,
  output logic [31:0] exRs1Data,
  output logic [31:0] exRs2Data,
  output logic [31:0] exImm,
  output logic [4:0]  exRd,
  output logic        exRegWrite,
  output logic        exMemRead,
  output logic        exMemWrite,
  output logic [5:0]  exOp,
  output logic [10:0] exFunc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [4:0] LINK_REG = 5'd31;

  logic [31:0] ifid_instr_reg;
  logic [31:0] ifid_pc_reg;
  logic [31:0] rf [0:31];

  logic [5:0]  op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_rtype;
  logic [10:0] func;
  logic [15:0] imm16;

  logic        is_rtype;
  logic        is_load;
  logic        is_store;
  logic        is_imm_alu;
  logic        is_j;
  logic        is_jal;
  logic        is_jr;
  logic        is_jalr;
  logic        uses_rs2;
  logic        writes_rd;
  logic        branch_reads_rs1;
  logic        jump_raw;
  logic [4:0]  dest_next;
  logic        reg_write_next;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        load_use;
  logic        branch_hazard;
  logic        flush;

  assign op       = ifid_instr_reg[31:26];
  assign rs1      = ifid_instr_reg[25:21];
  assign rs2      = ifid_instr_reg[20:16];
  assign rd_rtype = ifid_instr_reg[15:11];
  assign func     = ifid_instr_reg[10:0];
  assign imm16    = ifid_instr_reg[15:0];

  assign is_rtype   = (op == OP_RTYPE);
  assign is_load    = (op >= 6'h20) && (op <= 6'h25);
  assign is_store   = (op >= 6'h28) && (op <= 6'h2B);
  assign is_imm_alu = ((op >= 6'h08) && (op <= 6'h0F)) || ((op >= 6'h18) && (op <= 6'h1D));
  assign is_j       = (op == OP_J);
  assign is_jal     = (op == OP_JAL);
  assign is_jr      = (op == JR_OP);
  assign is_jalr    = (op == OP_JALR);
  assign uses_rs2   = is_rtype || is_store;
  assign writes_rd  = is_rtype || is_load || is_imm_alu || is_jal || is_jalr;

  always_comb begin
    dest_next = 5'd0;
    if (is_jal || is_jalr) begin
      dest_next = LINK_REG;
    end else if (is_rtype) begin
      dest_next = rd_rtype;
    end else if (writes_rd) begin
      dest_next = rs2;
    end
  end

  assign reg_write_next = writes_rd && (dest_next != 5'd0);

  // Reads see a same-cycle writeback so WB never needs a stall of its own.
  always_comb begin
    rs1_data = 32'd0;
    if (rs1 != 5'd0) begin
      rs1_data = (wbRegWrite && (wbRd == rs1)) ? wbData : rf[rs1];
    end
  end

  always_comb begin
    rs2_data = 32'd0;
    if (rs2 != 5'd0) begin
      rs2_data = (wbRegWrite && (wbRd == rs2)) ? wbData : rf[rs2];
    end
  end

  always_ff @(posedge clk) begin
    if (wbRegWrite && (wbRd != 5'd0)) begin
      rf[wbRd] <= wbData;
    end
  end

  assign BEQZ             = (op == OP_BEQZ);
  assign BNEZ             = (op == OP_BNEZ);
  assign jumpReg          = is_jr || is_jalr;
  assign jump_raw         = is_j || is_jal || is_jr || is_jalr;
  assign branch_reads_rs1 = BEQZ || BNEZ || jumpReg;

  assign registerS1  = rs1_data;
  assign zFlag       = (rs1_data == 32'd0);
  assign nzFlag      = ~zFlag;
  assign value       = ifid_instr_reg[25:0];
  assign extendedImm = {{16{imm16[15]}}, imm16};
  assign pcPlus4Id   = ifid_pc_reg;

  assign load_use = exMemRead && (exRd != 5'd0) &&
                    ((exRd == rs1) || (uses_rs2 && (exRd == rs2)));

  // Branches resolve here with only the WB bypass, so any producer still in EX or MEM must drain.
  assign branch_hazard = branch_reads_rs1 && (rs1 != 5'd0) &&
                         ((exRegWrite && (exRd == rs1)) ||
                          ((memRegWrite || memMemRead) && (memRd == rs1)));

  assign stall = load_use || branch_hazard;
  assign jump  = jump_raw && !stall;

`ifdef DECODE_DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = ((zFlag && BEQZ) || (nzFlag && BNEZ) || jump_raw) && !stall;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc_reg    <= 32'd0;
    end else if (stall) begin
      ifid_instr_reg <= ifid_instr_reg;
      ifid_pc_reg    <= ifid_pc_reg;
    end else if (flush) begin
      ifid_instr_reg <= NOP_INSTR;
      ifid_pc_reg    <= pcPlus4Out;
    end else begin
      ifid_instr_reg <= instruction;
      ifid_pc_reg    <= pcPlus4Out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      exRs1Data  <= 32'd0;
      exRs2Data  <= 32'd0;
      exImm      <= 32'd0;
      exRd       <= 5'd0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exMemWrite <= 1'b0;
      exOp       <= 6'd0;
      exFunc     <= 11'd0;
    end else begin
      exRs1Data  <= rs1_data;
      exRs2Data  <= rs2_data;
      exImm      <= extendedImm;
      exRd       <= dest_next;
      exRegWrite <= reg_write_next;
      exMemRead  <= is_load;
      exMemWrite <= is_store;
      exOp       <= op;
      exFunc     <= func;
    end
  end

endmodule

// File: tb/tb_pipeline_decode.sv
// Directed testbench for pipeline_decode: reset, branch flags, load-use, JR hazard,
// JAL flush/delay slot, r0 protection and reset during a stall.
module tb_pipeline_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pcPlus4Out;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        memRegWrite;
  logic        memMemRead;
  logic [4:0]  memRd;
  logic        stall, zFlag, nzFlag, BEQZ, BNEZ, jump, jumpReg;
  logic [25:0] value;
  logic [31:0] extendedImm, registerS1, pcPlus4Id;
  logic [31:0] exRs1Data, exRs2Data, exImm;
  logic [4:0]  exRd;
  logic        exRegWrite, exMemRead, exMemWrite;
  logic [5:0]  exOp;
  logic [10:0] exFunc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] I_BEQZ = 32'h1060_FFFC; // BEQZ r3, -4
  localparam logic [31:0] I_MARK = 32'h2001_0001; // ADDI r1, r0, 1
  localparam logic [31:0] I_LW   = 32'h8C25_0000; // LW r5, 0(r1)
  localparam logic [31:0] I_ADD  = 32'h00A7_3020; // ADD r6, r5, r7
  localparam logic [31:0] I_ADDI = 32'h2004_0005; // ADDI r4, r0, 5
  localparam logic [31:0] I_JR   = 32'h4880_0000; // JR r4
  localparam logic [31:0] I_JAL  = 32'h0FFF_FFFF; // JAL 26'h3FFFFFF

`ifdef DECODE_DELAY_SLOT_EN
  localparam logic [25:0] AFTER_TAKEN_VALUE = 26'h001_0001;
`else
  localparam logic [25:0] AFTER_TAKEN_VALUE = 26'h000_0000;
`endif

  pipeline_decode dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pcPlus4Out(pcPlus4Out),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
    .memRegWrite(memRegWrite), .memMemRead(memMemRead), .memRd(memRd),
    .stall(stall), .zFlag(zFlag), .nzFlag(nzFlag), .BEQZ(BEQZ), .BNEZ(BNEZ),
    .jump(jump), .jumpReg(jumpReg), .value(value), .extendedImm(extendedImm),
    .registerS1(registerS1), .pcPlus4Id(pcPlus4Id),
    .exRs1Data(exRs1Data), .exRs2Data(exRs2Data), .exImm(exImm), .exRd(exRd),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exOp(exOp), .exFunc(exFunc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instruction = NOP; pcPlus4Out = 32'h0;
    wbRegWrite = 1'b0; wbRd = 5'd0; wbData = 32'h0;
    memRegWrite = 1'b0; memMemRead = 1'b0; memRd = 5'd0;
    tick(); tick();
    reset = 1'b0; pcPlus4Out = 32'h4;
    #1;
    checks++; if (exRegWrite !== 1'b0) begin errors++; $display("FAIL reset_exRegWrite: got %0b expected 0", exRegWrite); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (pcPlus4Id !== 32'h0) begin errors++; $display("FAIL reset_pcPlus4Id: got %h expected 0", pcPlus4Id); end
    checks++; if (zFlag !== 1'b1) begin errors++; $display("FAIL reset_zFlag: got %0b expected 1", zFlag); end
    checks++; if (nzFlag !== 1'b0) begin errors++; $display("FAIL reset_nzFlag: got %0b expected 0", nzFlag); end
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL reset_jump: got %0b expected 0", jump); end
    checks++; if (exRd !== 5'd0) begin errors++; $display("FAIL reset_exRd: got %0d expected 0", exRd); end
    $display("reset: stall=%0b zFlag=%0b pcPlus4Id=%h", stall, zFlag, pcPlus4Id);
  endtask

  task automatic test_beqz();
    instruction = I_BEQZ; pcPlus4Out = 32'h100;
    tick();
    wbRegWrite = 1'b1; wbRd = 5'd3; wbData = 32'h0000_00AA; pcPlus4Out = 32'h104;
    #1;
    checks++; if (registerS1 !== 32'hAA) begin errors++; $display("FAIL beqz_bypass: got %h expected 000000aa", registerS1); end
    checks++; if (nzFlag !== 1'b1) begin errors++; $display("FAIL beqz_nzFlag: got %0b expected 1", nzFlag); end
    checks++; if (BEQZ !== 1'b1) begin errors++; $display("FAIL beqz_decode: got %0b expected 1", BEQZ); end
    tick();
    checks++; if (value !== 26'h060FFFC) begin errors++; $display("FAIL beqz_not_flushed: got %h expected 060fffc", value); end
    checks++; if (pcPlus4Id !== 32'h104) begin errors++; $display("FAIL beqz_pc: got %h expected 00000104", pcPlus4Id); end
    wbData = 32'h0; instruction = I_MARK; pcPlus4Out = 32'h108;
    #1;
    checks++; if (zFlag !== 1'b1) begin errors++; $display("FAIL beqz_zFlag: got %0b expected 1", zFlag); end
    checks++; if (extendedImm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beqz_imm: got %h expected fffffffc", extendedImm); end
    tick();
    wbRegWrite = 1'b0;
    #1;
    checks++; if (value !== AFTER_TAKEN_VALUE) begin errors++; $display("FAIL beqz_flush: got %h expected %h", value, AFTER_TAKEN_VALUE); end
    checks++; if (pcPlus4Id !== 32'h108) begin errors++; $display("FAIL beqz_flush_pc: got %h expected 00000108", pcPlus4Id); end
    checks++; if (exOp !== 6'h04) begin errors++; $display("FAIL beqz_exOp: got %h expected 04", exOp); end
    $display("beqz: taken, IF/ID value=%h pcPlus4Id=%h", value, pcPlus4Id);
  endtask

  task automatic test_load_use();
    instruction = I_LW; pcPlus4Out = 32'h1FC;
    tick();
    instruction = I_ADD; pcPlus4Out = 32'h200;
    tick();
    instruction = I_MARK; pcPlus4Out = 32'h204;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", stall); end
    checks++; if (exRd !== 5'd5 || exMemRead !== 1'b1) begin errors++; $display("FAIL lu_load_in_ex: got rd=%0d mr=%0b expected rd=5 mr=1", exRd, exMemRead); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b expected 0", stall); end
    checks++; if (exRd !== 5'd0 || exRegWrite !== 1'b0 || exMemRead !== 1'b0) begin errors++; $display("FAIL lu_bubble: got rd=%0d rw=%0b mr=%0b expected all 0", exRd, exRegWrite, exMemRead); end
    checks++; if (pcPlus4Id !== 32'h200) begin errors++; $display("FAIL lu_hold: got %h expected 00000200", pcPlus4Id); end
    tick();
    checks++; if (exRd !== 5'd6 || exRegWrite !== 1'b1) begin errors++; $display("FAIL lu_issue: got rd=%0d rw=%0b expected rd=6 rw=1", exRd, exRegWrite); end
    checks++; if (exFunc !== 11'h020) begin errors++; $display("FAIL lu_func: got %h expected 020", exFunc); end
    $display("load_use: ADD issued exRd=%0d exFunc=%h", exRd, exFunc);
  endtask

  task automatic test_jr_hazard();
    instruction = I_ADDI; pcPlus4Out = 32'h300;
    tick();
    instruction = I_JR; pcPlus4Out = 32'h304;
    tick();
    instruction = I_MARK; pcPlus4Out = 32'h308;
    #1;
    checks++; if (stall !== 1'b1 || jump !== 1'b0) begin errors++; $display("FAIL jr_ex_stall: got stall=%0b jump=%0b expected 1/0", stall, jump); end
    checks++; if (jumpReg !== 1'b1) begin errors++; $display("FAIL jr_jumpReg: got %0b expected 1", jumpReg); end
    tick();
    memRegWrite = 1'b1; memRd = 5'd4;
    #1;
    checks++; if (stall !== 1'b1 || jump !== 1'b0) begin errors++; $display("FAIL jr_mem_stall: got stall=%0b jump=%0b expected 1/0", stall, jump); end
    checks++; if (exRegWrite !== 1'b0) begin errors++; $display("FAIL jr_bubble: got %0b expected 0", exRegWrite); end
    tick();
    memRegWrite = 1'b0; memRd = 5'd0;
    wbRegWrite = 1'b1; wbRd = 5'd4; wbData = 32'h1234_5678;
    #1;
    checks++; if (stall !== 1'b0 || jump !== 1'b1 || jumpReg !== 1'b1) begin errors++; $display("FAIL jr_go: got stall=%0b jump=%0b jumpReg=%0b expected 0/1/1", stall, jump, jumpReg); end
    checks++; if (registerS1 !== 32'h1234_5678) begin errors++; $display("FAIL jr_target: got %h expected 12345678", registerS1); end
    tick();
    wbRegWrite = 1'b0;
    #1;
    checks++; if (value !== AFTER_TAKEN_VALUE) begin errors++; $display("FAIL jr_flush: got %h expected %h", value, AFTER_TAKEN_VALUE); end
    checks++; if (exOp !== 6'h12 || exRegWrite !== 1'b0) begin errors++; $display("FAIL jr_in_ex: got op=%h rw=%0b expected 12/0", exOp, exRegWrite); end
    $display("jr_hazard: target=%h", registerS1);
  endtask

  task automatic test_jal();
    instruction = I_JAL; pcPlus4Out = 32'h400;
    tick();
    instruction = I_MARK; pcPlus4Out = 32'h404;
    #1;
    checks++; if (jump !== 1'b1 || jumpReg !== 1'b0) begin errors++; $display("FAIL jal_jump: got jump=%0b jumpReg=%0b expected 1/0", jump, jumpReg); end
    checks++; if (value !== 26'h3FFFFFF) begin errors++; $display("FAIL jal_value: got %h expected 3ffffff", value); end
    tick();
    checks++; if (exRd !== 5'd31 || exRegWrite !== 1'b1) begin errors++; $display("FAIL jal_link: got rd=%0d rw=%0b expected 31/1", exRd, exRegWrite); end
    checks++; if (value !== AFTER_TAKEN_VALUE) begin errors++; $display("FAIL jal_flush: got %h expected %h", value, AFTER_TAKEN_VALUE); end
    checks++; if (pcPlus4Id !== 32'h404) begin errors++; $display("FAIL jal_pc: got %h expected 00000404", pcPlus4Id); end
    $display("jal: exRd=%0d next value=%h", exRd, value);
  endtask

  task automatic test_r0();
    wbRegWrite = 1'b1; wbRd = 5'd0; wbData = 32'hFFFF_FFFF;
    instruction = I_MARK; pcPlus4Out = 32'h500;
    tick();
    checks++; if (registerS1 !== 32'h0 || zFlag !== 1'b1 || nzFlag !== 1'b0) begin errors++; $display("FAIL r0_bypass: got %h z=%0b expected 0 z=1", registerS1, zFlag); end
    wbRegWrite = 1'b0;
    tick();
    checks++; if (registerS1 !== 32'h0 || zFlag !== 1'b1) begin errors++; $display("FAIL r0_stored: got %h z=%0b expected 0 z=1", registerS1, zFlag); end
    $display("r0: registerS1=%h zFlag=%0b", registerS1, zFlag);
  endtask

  task automatic test_reset_mid_stall();
    instruction = I_LW; pcPlus4Out = 32'h600;
    tick();
    instruction = I_ADD; pcPlus4Out = 32'h604;
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall: got %0b expected 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || exMemRead !== 1'b0) begin errors++; $display("FAIL rms_clear: got stall=%0b mr=%0b expected 0/0", stall, exMemRead); end
    checks++; if (pcPlus4Id !== 32'h0 || value !== 26'h0) begin errors++; $display("FAIL rms_ifid: got pc=%h value=%h expected 0/0", pcPlus4Id, value); end
    $display("reset_mid_stall: stall=%0b pcPlus4Id=%h", stall, pcPlus4Id);
  endtask

  initial begin
    test_reset();
    test_beqz();
    test_load_use();
    test_jr_hazard();
    test_jal();
    test_r0();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
